note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameters: NOTE_W, 32, frequency field width (Hz).
REQ-002 SHALL have parameters: DEPTH, 64, song memory entries; ADDR_W = $clog2(DEPTH).
REQ-003 SHALL have parameters: LEN_W, 3, note-length field width (length units).
REQ-004 SHALL have parameters: TICK_CYCLES, 10000000, clock cycles per length unit.
REQ-005 FPGA_CLK1_50  in  1  sole clock, all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  write strobe for song memory.
REQ-008 wr_addr  in  ADDR_W  write address.
REQ-009 wr_freq  in  NOTE_W  note frequency, 0 = rest.
REQ-010 wr_len  in  LEN_W  note length in units.
REQ-011 song_len  in  ADDR_W+1  number of entries to play, sampled on start.
REQ-012 start  in  1  one-cycle play request.
REQ-013 stop  in  1  abort request.
REQ-014 loop  in  1  restart at entry 0 after last note instead of finishing.
REQ-015 live_freq  in  NOTE_W  keyboard free-mode frequency.
REQ-016 desiredFrequency  out  NOTE_W  tone to speaker driver.
REQ-017 busy  out  1  high while not IDLE.
REQ-018 done  out  1  one-cycle pulse at normal completion.
REQ-019 note_idx  out  ADDR_W  entry currently sounding.

Function
REQ-020 States SHALL be IDLE, FETCH, PLAY, and GAP (GAP only with SEQ_GAP_EN).
REQ-021 In IDLE, desiredFrequency SHALL equal live_freq delayed one cycle.
REQ-022 wr_en SHALL write {wr_freq, wr_len} at wr_addr only in IDLE; writes while busy SHALL be ignored.
REQ-023 start in IDLE with song_len > 0 SHALL latch song_len, set note_idx=0, enter FETCH next cycle.
REQ-024 start in IDLE with song_len = 0 SHALL pulse done next cycle and remain IDLE.
REQ-025 start while busy SHALL be ignored.
REQ-026 FETCH (one cycle) SHALL read entry note_idx; if len = 0, the entry is skipped and FETCH repeats with the next index; otherwise load counter = len*TICK_CYCLES-1 and enter PLAY.
REQ-027 In PLAY, desiredFrequency SHALL hold the entry frequency for exactly len*TICK_CYCLES cycles, output from the first PLAY cycle.
REQ-028 In FETCH, desiredFrequency SHALL be 0.
REQ-029 At counter 0, if note_idx < latched_len-1, SHALL increment note_idx and go to FETCH (or GAP).
REQ-030 At counter 0 on the last entry with loop=1, SHALL set note_idx=0 and continue, without a done pulse.
REQ-031 At counter 0 on the last entry with loop=0, SHALL pulse done, go to IDLE, and set desiredFrequency=0 for that cycle.
REQ-032 stop SHALL force IDLE on the next edge from any state, with no done pulse; stop beats start in the same cycle.
REQ-033 Counter and multiply SHALL be sized for (2^LEN_W-1)*TICK_CYCLES without overflow.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 reset_n low SHALL asynchronously force IDLE, desiredFrequency=0, busy=0, done=0, note_idx=0, counter=0, latched_len=0.
REQ-036 Song memory SHALL NOT be reset; its contents after reset are undefined.
REQ-037 Reset asserted mid-song SHALL abort playback with no done pulse.

Configuration
REQ-038 SEQ_GAP_EN defined: after each PLAY, SHALL spend TICK_CYCLES/8 cycles (minimum 1) in GAP with desiredFrequency=0 before FETCH or completion (articulation).
REQ-039 SEQ_GAP_EN undefined: no GAP state; PLAY transitions directly as in REQ-029..031.

Verification (TICK_CYCLES=4, DEPTH=8, LEN_W=3, no SEQ_GAP_EN unless stated)
REQ-040 Write {440,2},{0,1},{494,1}; song_len=3; start -> 440 for 8 cycles, 0 for 1 FETCH cycle, 0 for 4 cycles, 0 for 1 FETCH cycle, 494 for 4 cycles, then done pulse and IDLE.
REQ-041 Entry {330,0} between two notes -> skipped; note_idx jumps past it, with 330 never output.
REQ-042 loop=1, song_len=2 -> note_idx sequence 0,1,0,1..., no done pulse; deassert loop -> done after the next entry 1.
REQ-043 stop during the second note -> IDLE next cycle; desiredFrequency follows live_freq=261 after one cycle; no done pulse.
REQ-044 reset_n low mid-PLAY -> all outputs 0 immediately; wr_en while busy -> memory unchanged (read back after completion); start with song_len=0 -> done pulse only.
REQ-045 With SEQ_GAP_EN -> 1-cycle zero gap after each PLAY.

Source files
------------

// File: rtl/note_sequencer.sv
// Song-memory note sequencer: plays {freq,len} entries as timed tones and passes live_freq through when idle.
// Optional macro SEQ_GAP_EN adds a silent articulation gap of TICK_CYCLES/8 (min 1) cycles after every played note.
module note_sequencer #(
   parameter  int NOTE_W      = 32,
   parameter  int DEPTH       = 64,
   parameter  int LEN_W       = 3,
   parameter  int TICK_CYCLES = 10000000,
   localparam int ADDR_W      = $clog2(DEPTH)
) (
   input  logic              FPGA_CLK1_50,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [NOTE_W-1:0] wr_freq,
   input  logic [LEN_W-1:0]  wr_len,
   input  logic [ADDR_W:0]   song_len,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
   input  logic [NOTE_W-1:0] live_freq,
   output logic [NOTE_W-1:0] desiredFrequency,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] note_idx,
   output logic [1:0]        fsm_state
);

   // start/stop are single-cycle requests with no ready: start is acted on only in IDLE,
   // stop is acted on in every state and always wins over start.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_PLAY  = 2'd2
`ifdef SEQ_GAP_EN
      , S_GAP = 2'd3
`endif
   } state_t;

   // Counter must hold the longest note, (2^LEN_W-1)*TICK_CYCLES cycles.
   localparam longint unsigned MAX_CYCLES = ((64'd1 << LEN_W) - 64'd1) * 64'(TICK_CYCLES);
   localparam int CNT_W = $clog2(MAX_CYCLES + 64'd1);
`ifdef SEQ_GAP_EN
   localparam int GAP_RAW    = TICK_CYCLES / 8;
   localparam int GAP_CYCLES = (GAP_RAW < 1) ? 1 : GAP_RAW;
`endif

   state_t                  state, state_nx;
   logic [NOTE_W+LEN_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]        counter, counter_nx;
   logic [ADDR_W:0]         latched_len, latched_len_nx;
   logic [ADDR_W-1:0]       note_idx_nx;
   logic [NOTE_W-1:0]       freq_nx;
   logic                    done_nx;
   logic [NOTE_W-1:0]       entry_freq;
   logic [LEN_W-1:0]        entry_len;
   logic                    is_last, cnt_zero, entry_end, finish;

   assign entry_freq = mem[note_idx][NOTE_W+LEN_W-1:LEN_W];
   assign entry_len  = mem[note_idx][LEN_W-1:0];
   assign is_last    = ({1'b0, note_idx} + (ADDR_W+1)'(1)) >= latched_len;
   assign cnt_zero   = (counter == '0);
   assign finish     = entry_end && is_last && !loop;
   assign fsm_state  = state;

   // Song memory has no reset; it is only writable while idle.
   always_ff @(posedge FPGA_CLK1_50) begin
      if (wr_en && state == S_IDLE) begin
         mem[wr_addr] <= {wr_freq, wr_len};
      end
   end

   // An entry is finished when a zero-length entry is fetched or its last timed cycle elapses.
   always_comb begin
      entry_end = 1'b0;
      case (state)
         S_FETCH: entry_end = (entry_len == '0);
`ifdef SEQ_GAP_EN
         S_GAP:   entry_end = cnt_zero;
`else
         S_PLAY:  entry_end = cnt_zero;
`endif
         default: entry_end = 1'b0;
      endcase
   end

   always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         counter          <= '0;
         latched_len      <= '0;
         note_idx         <= '0;
         desiredFrequency <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         state            <= state_nx;
         counter          <= counter_nx;
         latched_len      <= latched_len_nx;
         note_idx         <= note_idx_nx;
         desiredFrequency <= freq_nx;
         busy             <= (state_nx != S_IDLE);
         done             <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start && song_len != '0) state_nx = S_FETCH;
         end
         S_FETCH: begin
            if (entry_len != '0) state_nx = S_PLAY;
         end
         S_PLAY: begin
`ifdef SEQ_GAP_EN
            if (cnt_zero) state_nx = S_GAP;
`endif
         end
         default: state_nx = state;
      endcase
      if (entry_end) state_nx = finish ? S_IDLE : S_FETCH;
      if (stop) state_nx = S_IDLE;
   end

   always_comb begin
      counter_nx     = counter;
      latched_len_nx = latched_len;
      note_idx_nx    = note_idx;
      freq_nx        = '0;
      done_nx        = 1'b0;
      case (state)
         S_IDLE: begin
            freq_nx = live_freq;
            if (start) begin
               if (song_len != '0) begin
                  latched_len_nx = song_len;
                  note_idx_nx    = '0;
                  freq_nx        = '0;
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         S_FETCH: begin
            if (entry_len != '0) begin
               counter_nx = CNT_W'(entry_len) * CNT_W'(TICK_CYCLES) - CNT_W'(1);
               freq_nx    = entry_freq;
            end
         end
         S_PLAY: begin
            freq_nx = desiredFrequency;
            if (!cnt_zero) begin
               counter_nx = counter - CNT_W'(1);
            end else begin
               freq_nx = '0;
`ifdef SEQ_GAP_EN
               counter_nx = CNT_W'(GAP_CYCLES - 1);
`endif
            end
         end
`ifdef SEQ_GAP_EN
         S_GAP: begin
            if (!cnt_zero) counter_nx = counter - CNT_W'(1);
         end
`endif
         default: freq_nx = '0;
      endcase
      if (entry_end) begin
         if (!is_last) begin
            note_idx_nx = note_idx + ADDR_W'(1);
         end else if (loop) begin
            note_idx_nx = '0;
         end else begin
            done_nx = 1'b1;
         end
      end
      if (stop) begin
         counter_nx     = counter;
         latched_len_nx = latched_len;
         note_idx_nx    = note_idx;
         freq_nx        = live_freq;
         done_nx        = 1'b0;
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: random songs against a per-cycle trace built from the song memory contents.
module tb_note_sequencer;

   localparam int NOTE_W = 32;
   localparam int DEPTH  = 8;
   localparam int LEN_W  = 3;
   localparam int TICK   = 4;
   localparam int ADDR_W = 3;
`ifdef SEQ_GAP_EN
   localparam int GAPC = (TICK / 8 < 1) ? 1 : TICK / 8;
`else
   localparam int GAPC = 0;
`endif
   localparam int EXP_W = 2 + ADDR_W + NOTE_W;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [NOTE_W-1:0] wr_freq = '0;
   logic [LEN_W-1:0]  wr_len = '0;
   logic [ADDR_W:0]   song_len = '0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              loop = 1'b0;
   logic [NOTE_W-1:0] live_freq = '0;
   logic [NOTE_W-1:0] desired_frequency;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] note_idx;
   logic [1:0]        fsm_state;

   int checks = 0;
   int failures = 0;
   int unsigned m_freq [DEPTH];
   int unsigned m_len  [DEPTH];
   logic [EXP_W-1:0] exp_q [$];

   note_sequencer #(.NOTE_W(NOTE_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .TICK_CYCLES(TICK)) dut (
      .FPGA_CLK1_50(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_freq(wr_freq), .wr_len(wr_len), .song_len(song_len), .start(start),
      .stop(stop), .loop(loop), .live_freq(live_freq),
      .desiredFrequency(desired_frequency), .busy(busy), .done(done),
      .note_idx(note_idx), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_out(input string tag, input logic [NOTE_W-1:0] f);
      check_eq({tag, "_freq"}, 64'(desired_frequency), 64'(f));
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_done"}, 64'(done), 64'd0);
   endtask

   task automatic idle_cycle();
      logic [NOTE_W-1:0] l;
      l = NOTE_W'($urandom_range(0, 5000));
      live_freq = l;
      tick();
      check_idle_out("idle", l);
   endtask

   task automatic write_entry(input int a, input int unsigned f, input int unsigned len);
      logic [NOTE_W-1:0] l;
      l = NOTE_W'($urandom_range(0, 5000));
      wr_en = 1'b1;
      wr_addr = ADDR_W'(a);
      wr_freq = NOTE_W'(f);
      wr_len = LEN_W'(len);
      live_freq = l;
      tick();
      wr_en = 1'b0;
      m_freq[a] = f;
      m_len[a] = len;
      check_idle_out("wr", l);
   endtask

   function automatic logic [EXP_W-1:0] pack(input logic b, input logic d, input int i, input int unsigned f);
      return {b, d, ADDR_W'(i), NOTE_W'(f)};
   endfunction

   // Cycles in one pass over entries 0..n-1: fetch, then len*TICK tone cycles and the gap.
   function automatic int pass_len(input int n);
      int cnt = 0;
      for (int i = 0; i < n; i++) begin
         cnt += 1;
         if (m_len[i] != 0) cnt += int'(m_len[i]) * TICK + GAPC;
      end
      return cnt;
   endfunction

   function automatic void push_pass(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(pack(1'b1, 1'b0, i, 0));
         if (m_len[i] != 0) begin
            for (int c = 0; c < int'(m_len[i]) * TICK; c++) exp_q.push_back(pack(1'b1, 1'b0, i, m_freq[i]));
            for (int g = 0; g < GAPC; g++) exp_q.push_back(pack(1'b1, 1'b0, i, 0));
         end
      end
   endfunction

   // abort_kind 0 = stop, 1 = reset; negative abort_at/inject_at disable that event.
   task automatic run_song(input int n, input int passes, input int abort_at, input int abort_kind, input int inject_at);
      int p_items;
      int k;
      logic [EXP_W-1:0] e;
      logic [NOTE_W-1:0] l;
      exp_q.delete();
      p_items = pass_len(n);
      for (int p = 0; p <= passes; p++) push_pass(n);
      exp_q.push_back(pack(1'b0, 1'b1, n - 1, 0));
      l = NOTE_W'($urandom_range(0, 5000));
      loop = (passes > 0);
      song_len = (ADDR_W+1)'(n);
      start = 1'b1;
      live_freq = l;
      tick();
      start = 1'b0;
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("seq_freq", 64'(desired_frequency), 64'(e[NOTE_W-1:0]));
         check_eq("seq_idx", 64'(note_idx), 64'(e[NOTE_W +: ADDR_W]));
         check_eq("seq_busy", 64'(busy), 64'(e[EXP_W-1]));
         check_eq("seq_done", 64'(done), 64'(e[EXP_W-2]));
         if (k == abort_at) begin
            if (abort_kind == 0) begin
               stop = 1'b1;
               live_freq = 261;
               tick();
               stop = 1'b0;
               check_idle_out("stop", 261);
               tick();
               check_idle_out("stop_hold", 261);
            end else begin
               reset_n = 1'b0;
               #1;
               check_eq("rst_freq", 64'(desired_frequency), 64'd0);
               check_eq("rst_busy", 64'(busy), 64'd0);
               check_eq("rst_done", 64'(done), 64'd0);
               check_eq("rst_idx", 64'(note_idx), 64'd0);
               #1;
               reset_n = 1'b1;
               tick();
               check_idle_out("rst_rel", l);
            end
            exp_q.delete();
            break;
         end
         if (passes > 0 && k == passes * p_items) loop = 1'b0;
         if (k == inject_at) begin
            start = 1'b1;
            song_len = (ADDR_W+1)'($urandom_range(1, DEPTH));
            wr_en = 1'b1;
            wr_addr = ADDR_W'($urandom_range(0, 2));
            wr_freq = 999;
            wr_len = 5;
         end
         tick();
         start = 1'b0;
         wr_en = 1'b0;
         k++;
      end
      loop = 1'b0;
      if (abort_at < 0) check_idle_out("post_done", l);
      idle_cycle();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NOTE_W-1:0] l;
      int n, passes, total, abort_at, kind, inject_at;
      #1;
      check_eq("reset_freq", 64'(desired_frequency), 64'd0);
      check_eq("reset_busy", 64'(busy), 64'd0);
      check_eq("reset_done", 64'(done), 64'd0);
      check_eq("reset_idx", 64'(note_idx), 64'd0);
      check_eq("reset_state", 64'(fsm_state), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) idle_cycle();

      // Rest entry in the middle of a two-note song.
      write_entry(0, 440, 2);
      write_entry(1, 0, 1);
      write_entry(2, 494, 1);
      run_song(3, 0, -1, 0, -1);

      // Zero-length entry is skipped.
      write_entry(1, 330, 0);
      run_song(3, 0, -1, 0, -1);

      // Two-entry loop for three passes, loop dropped during the fourth.
      write_entry(0, 523, 1);
      write_entry(1, 659, 2);
      run_song(2, 3, -1, 0, -1);

      // Stop during the second note, then reset during the first.
      write_entry(0, 262, 2);
      write_entry(1, 392, 3);
      run_song(2, 0, 1 + 2 * TICK + GAPC + 2, 0, -1);
      run_song(2, 0, 4, 1, -1);

      // Writes and start while busy must not disturb the song; replay shows memory intact.
      write_entry(0, 440, 2);
      write_entry(1, 0, 1);
      write_entry(2, 494, 1);
      run_song(3, 0, -1, 0, 4);
      run_song(3, 0, -1, 0, -1);

      // Empty song only pulses done.
      l = NOTE_W'($urandom_range(0, 5000));
      live_freq = l;
      song_len = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("empty_done", 64'(done), 64'd1);
      check_eq("empty_busy", 64'(busy), 64'd0);
      check_eq("empty_freq", 64'(desired_frequency), 64'(l));
      tick();
      check_idle_out("empty_after", l);

      // Stop wins over start in the same cycle.
      song_len = 3;
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      check_idle_out("stop_start", l);
      tick();
      check_idle_out("stop_start_hold", l);

      for (int it = 0; it < 20; it++) begin
         for (int a = 0; a < DEPTH; a++) begin
            write_entry(a, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4000),
                        ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 7));
         end
         n = $urandom_range(1, DEPTH);
         passes = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         total = (passes + 1) * pass_len(n) + 1;
         abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 2)) : -1;
         kind = $urandom_range(0, 1);
         inject_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, total - 2)) : -1;
         run_song(n, passes, abort_at, kind, inject_at);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
